sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single-port 32x256 instruction SRAM between two requesters: the loader path, which writes and reads back program words, and the CPU fetch port, which only reads. It sits between the core, the loader and the SRAM macro, and replaces the direct core-to-macro wiring. It also registers all macro control signals and returns read data to the requester that issued the read. Throughput is one access per cycle.

## Interface
- AW, 8, address width (256 words)
- DW, 32, data width
- CLK  in  1  single clock; every register updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ld_mode  in  1  1 = loader owns the SRAM and CPU requests are never granted
- ld_req  in  1  loader access request
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  AW  loader word address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DW  loader read data
- cpu_req  in  1  CPU fetch request (read only)
- cpu_addr  in  AW  fetch word address
- cpu_gnt  out  1  fetch accepted this cycle
- cpu_rvalid  out  1  fetch data valid
- cpu_rdata  out  DW  fetch data
- sram_csb  out  1  macro chip select, active-low, registered
- sram_web  out  1  macro write enable, active-low, registered
- sram_addr  out  AW  macro address, registered
- sram_din  out  DW  macro write data, registered
- sram_dout  in  DW  macro read data; valid one cycle after the read is presented
- wr_count  out  AW+1  number of loader writes issued since reset, saturating at 256

## Operation
- Grant is combinational in the request cycle N. A request holds its req, addr and data until it sees its gnt.
- Arbitration:
  - ld_mode=1: only ld_req is considered; cpu_gnt=0.
  - ld_mode=0 with only one request active: that request is granted.
  - ld_mode=0 with both requests active: round-robin, the requester not granted last wins.
  - The last-granted pointer updates only on a granted cycle and resets to "CPU last", so the loader wins the first conflict after reset.
- Granted access:
  - At the edge ending cycle N, the block registers sram_csb=0, sram_web=~we, sram_addr and sram_din.
  - A write from the loader carries its data in sram_din. A CPU fetch or loader read drives sram_din=0.
  - Cycles with no grant register sram_csb=1 and sram_web=1; sram_addr and sram_din hold their previous values.
- Read return:
  - A 2-stage owner tag pipeline (valid + owner bit) follows each read.
  - In cycle N+2, {ld|cpu}_rvalid=1 for exactly one cycle, and the rdata of the owner equals sram_dout.
  - The non-owner's rvalid=0 and its rdata is held at its last value.
- Writes return no rvalid.
- wr_count increments on every granted loader write (ld_gnt & ld_we) and saturates at 256.
- Reads and writes to the same address are serviced in grant order. A read granted in the cycle after a write to the same address returns the new data, because the macro serialises them.

## Timing
- Request-to-grant latency: 0 cycles. Grant to macro pins: 1 cycle. Grant to rvalid: 2 cycles.
- Back-to-back grants every cycle are legal; up to 2 reads can be in flight at once.
- Reset values:
  - sram_csb=1, sram_web=1, sram_addr=0, sram_din=0
  - ld_rvalid=0, cpu_rvalid=0, ld_rdata=0, cpu_rdata=0
  - wr_count=0, tag pipeline empty
- ld_gnt and cpu_gnt are forced to 0 while reset is high.
- Reset asserted mid-operation: in-flight reads are dropped and no rvalid is generated for them. sram_csb goes to 1 asynchronously.
- ld_mode changing while a CPU read is in flight: that read still completes to the CPU. Only new grants follow the new mode.
- Simultaneous request in the same cycle as reset deassertion: the request is not granted until the first rising edge with reset low has passed.

## Test plan
- Reset: assert reset mid-stream with 2 reads in flight → sram_csb=1 immediately, no rvalid afterwards, wr_count=0.
- Loader write then read:
  - Stimulus: ld_mode=1; write 0xDEADBEEF to address 0x05, then read 0x05.
  - Required: ld_gnt=1 on both cycles; sram_web=0, then 1; ld_rvalid 2 cycles after the read grant with ld_rdata=0xDEADBEEF; wr_count=1.
- Mode lock:
  - Stimulus: ld_mode=1, cpu_req=1 held for 10 cycles.
  - Required: cpu_gnt=0 throughout. After ld_mode drops, cpu_gnt=1 in the next cycle.
- Round-robin:
  - Stimulus: ld_mode=0; both requesters reading continuously from 0x10 (loader) and 0x20 (CPU).
  - Required: grants alternate LD, CPU, LD, …; each rvalid goes to the correct owner with the matching data.
- Full load:
  - Stimulus: 256 consecutive loader writes, data = address × 3, then a 257th write.
  - Required: wr_count=256 and it saturates. CPU fetches of 0x00–0xFF return address × 3 at 1 word per cycle after the 2-cycle latency.
- Mode switch in flight:
  - Stimulus: CPU read granted, ld_mode rises the next cycle.
  - Required: cpu_rvalid still asserts at N+2 with the correct data.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port 32x256 instruction SRAM between
// the loader (read/write) and the CPU fetch port (read only). Grants are
// combinational and round-robin on conflict. All macro controls are
// registered. Read data is steered back to its owner through a 2-stage tag
// pipeline.
//
// Handshake: a requester holds req/addr/data stable until it sees gnt high
// in the same cycle. The beat is accepted at the rising edge that ends that
// cycle. rvalid is a one-cycle strobe with no back-pressure. Its rdata equals
// sram_dout in that cycle and is held afterwards.
module sram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          ld_mode,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          sram_csb,
    output logic          sram_web,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic [AW:0]   wr_count
);

    localparam logic [AW:0] WR_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] WR_ONE = {{AW{1'b0}}, 1'b1};

    // init_q stays low until the first rising edge with reset low has
    // passed, so a request that shows up as reset falls is not granted early.
    logic          init_q, init_d;
    // 1 = loader was granted last; 0 = CPU was granted last.
    logic          last_ld_q, last_ld_d;
    logic          csb_q, csb_d;
    logic          web_q, web_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    // Tag pipeline: valid + owner (1 = loader) for each read in flight.
    logic          rv1_q, rv1_d, own1_q, own1_d;
    logic          rv2_q, rv2_d, own2_q, own2_d;
    logic [DW-1:0] ld_rdata_q, ld_rdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [AW:0]   wr_count_q, wr_count_d;

    // Arbitration: loader-only in ld_mode, otherwise single requester wins or
    // round-robin on conflict. Nothing is granted while reset is high or before init.
    always_comb begin
        ld_gnt  = 1'b0;
        cpu_gnt = 1'b0;
        if (init_q && !reset) begin
            if (ld_mode) begin
                ld_gnt = ld_req;
            end else if (ld_req && cpu_req) begin
                ld_gnt  = ~last_ld_q;
                cpu_gnt = last_ld_q;
            end else begin
                ld_gnt  = ld_req;
                cpu_gnt = cpu_req;
            end
        end
    end

    // Read return: the stage-2 tag selects which port sees sram_dout this cycle.
    always_comb begin
        ld_rvalid  = rv2_q & own2_q;
        cpu_rvalid = rv2_q & ~own2_q;
        ld_rdata   = ld_rvalid  ? sram_dout : ld_rdata_q;
        cpu_rdata  = cpu_rvalid ? sram_dout : cpu_rdata_q;
    end

    // Next-state for macro pins, tags, round-robin pointer and write counter.
    always_comb begin
        init_d      = 1'b1;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        addr_d      = addr_q;
        din_d       = din_q;
        last_ld_d   = last_ld_q;
        rv1_d       = 1'b0;
        own1_d      = 1'b0;
        rv2_d       = rv1_q;
        own2_d      = own1_q;
        ld_rdata_d  = ld_rdata;
        cpu_rdata_d = cpu_rdata;
        wr_count_d  = wr_count_q;
        if (ld_gnt) begin
            csb_d     = 1'b0;
            web_d     = ~ld_we;
            addr_d    = ld_addr;
            din_d     = ld_we ? ld_wdata : '0;
            last_ld_d = 1'b1;
            rv1_d     = ~ld_we;
            own1_d    = 1'b1;
            if (ld_we && (wr_count_q != WR_MAX)) begin
                wr_count_d = wr_count_q + WR_ONE;
            end
        end else if (cpu_gnt) begin
            csb_d     = 1'b0;
            web_d     = 1'b1;
            addr_d    = cpu_addr;
            din_d     = '0;
            last_ld_d = 1'b0;
            rv1_d     = 1'b1;
            own1_d    = 1'b0;
        end
    end

    // State registers; reset idles the macro and drops in-flight reads.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            init_q      <= 1'b0;
            last_ld_q   <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            addr_q      <= '0;
            din_q       <= '0;
            rv1_q       <= 1'b0;
            own1_q      <= 1'b0;
            rv2_q       <= 1'b0;
            own2_q      <= 1'b0;
            ld_rdata_q  <= '0;
            cpu_rdata_q <= '0;
            wr_count_q  <= '0;
        end else begin
            init_q      <= init_d;
            last_ld_q   <= last_ld_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rv1_q       <= rv1_d;
            own1_q      <= own1_d;
            rv2_q       <= rv2_d;
            own2_q      <= own2_d;
            ld_rdata_q  <= ld_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign sram_csb  = csb_q;
    assign sram_web  = web_q;
    assign sram_addr = addr_q;
    assign sram_din  = din_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a behavioural SRAM macro, a table of
// per-cycle vectors, and directed sequences for reset, mode switching, a
// full load and streaming fetches.
module tb_sram_port_arbiter;

    logic        CLK;
    logic        reset;
    logic        ld_mode, ld_req, ld_we, cpu_req;
    logic [7:0]  ld_addr, cpu_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid;
    logic [31:0] ld_rdata, cpu_rdata;
    logic        sram_csb, sram_web;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din, sram_dout;
    logic [8:0]  wr_count;

    int cmp_cnt = 0;
    int err_cnt = 0;

    sram_port_arbiter #(.AW(8), .DW(32)) dut (
        .CLK(CLK), .reset(reset), .ld_mode(ld_mode),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .wr_count(wr_count)
    );

    // Clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural single-port macro: data appears one cycle after the pins.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        sram_dout = '0;
    end
    always @(posedge CLK) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_addr] <= sram_din;
            else           sram_dout      <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic lr, input logic lw, input logic [7:0] la,
                         input logic [31:0] lwd, input logic cr, input logic [7:0] ca);
        ld_mode = m; ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd;
        cpu_req = cr; cpu_addr = ca;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic m, lr, lw; logic [7:0] la; logic [31:0] lwd; logic cr; logic [7:0] ca;
        logic e_lg, e_cg, e_lrv; logic [31:0] e_lrd; logic e_crv; logic [31:0] e_crd;
        logic e_csb, e_web; logic [8:0] e_wc;
    } vec_t;

    vec_t vecs [14];
    logic [31:0] exp_q [$];

    initial begin
        int rv_cnt;
        logic [31:0] want;

        // mode lr lw la lwd cr ca | lg cg lrv lrd crv crd csb web wc
        vecs[0]  = '{1'b1,1'b1,1'b1,8'h10,32'h11110010,1'b1,8'h20, 1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b1,9'd0};
        vecs[1]  = '{1'b1,1'b1,1'b1,8'h20,32'h22220020,1'b1,8'h20, 1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,9'd1};
        vecs[2]  = '{1'b1,1'b1,1'b1,8'h05,32'hDEADBEEF,1'b1,8'h20, 1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,9'd2};
        vecs[3]  = '{1'b1,1'b1,1'b0,8'h05,32'h0,       1'b1,8'h20, 1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,9'd3};
        vecs[4]  = '{1'b1,1'b0,1'b0,8'h00,32'h0,       1'b1,8'h20, 1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,9'd3};
        vecs[5]  = '{1'b1,1'b0,1'b0,8'h00,32'h0,       1'b1,8'h20, 1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0,1'b1,1'b1,9'd3};
        vecs[6]  = '{1'b0,1'b0,1'b0,8'h00,32'h0,       1'b1,8'h20, 1'b0,1'b1,1'b0,32'hDEADBEEF,1'b0,32'h0,1'b1,1'b1,9'd3};
        vecs[7]  = '{1'b0,1'b1,1'b0,8'h10,32'h0,       1'b1,8'h20, 1'b1,1'b0,1'b0,32'hDEADBEEF,1'b0,32'h0,1'b0,1'b1,9'd3};
        vecs[8]  = '{1'b0,1'b1,1'b0,8'h10,32'h0,       1'b1,8'h20, 1'b0,1'b1,1'b0,32'hDEADBEEF,1'b1,32'h22220020,1'b0,1'b1,9'd3};
        vecs[9]  = '{1'b0,1'b1,1'b0,8'h10,32'h0,       1'b1,8'h20, 1'b1,1'b0,1'b1,32'h11110010,1'b0,32'h22220020,1'b0,1'b1,9'd3};
        vecs[10] = '{1'b0,1'b1,1'b0,8'h10,32'h0,       1'b1,8'h20, 1'b0,1'b1,1'b0,32'h11110010,1'b1,32'h22220020,1'b0,1'b1,9'd3};
        vecs[11] = '{1'b0,1'b0,1'b0,8'h00,32'h0,       1'b0,8'h00, 1'b0,1'b0,1'b1,32'h11110010,1'b0,32'h22220020,1'b0,1'b1,9'd3};
        vecs[12] = '{1'b0,1'b0,1'b0,8'h00,32'h0,       1'b0,8'h00, 1'b0,1'b0,1'b0,32'h11110010,1'b1,32'h22220020,1'b1,1'b1,9'd3};
        vecs[13] = '{1'b0,1'b0,1'b0,8'h00,32'h0,       1'b0,8'h00, 1'b0,1'b0,1'b0,32'h11110010,1'b0,32'h22220020,1'b1,1'b1,9'd3};

        // Reset values, with a loader request already present.
        reset = 1'b1;
        drive(1, 1, 0, 8'h00, 0, 1, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        check("rst ld_gnt", ld_gnt, 0);
        check("rst cpu_gnt", cpu_gnt, 0);
        check("rst csb", sram_csb, 1);
        check("rst web", sram_web, 1);
        check("rst addr", sram_addr, 0);
        check("rst din", sram_din, 0);
        check("rst ld_rvalid", ld_rvalid, 0);
        check("rst cpu_rvalid", cpu_rvalid, 0);
        check("rst ld_rdata", ld_rdata, 0);
        check("rst cpu_rdata", cpu_rdata, 0);
        check("rst wr_count", wr_count, 0);

        // Request held across reset release: granted only after the first edge.
        drive(1, 1, 0, 8'h00, 0, 0, 8'h00);
        reset = 1'b0;
        @(negedge CLK);
        check("release no gnt", ld_gnt, 0);
        tick();
        @(negedge CLK);
        check("release gnt", ld_gnt, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Table: loader writes, write-then-read, mode lock, round-robin.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].m, vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].lwd, vecs[i].cr, vecs[i].ca);
            @(negedge CLK);
            check($sformatf("v%0d ld_gnt", i), ld_gnt, vecs[i].e_lg);
            check($sformatf("v%0d cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
            check($sformatf("v%0d ld_rvalid", i), ld_rvalid, vecs[i].e_lrv);
            check($sformatf("v%0d ld_rdata", i), ld_rdata, vecs[i].e_lrd);
            check($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
            check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
            check($sformatf("v%0d csb", i), sram_csb, vecs[i].e_csb);
            check($sformatf("v%0d web", i), sram_web, vecs[i].e_web);
            check($sformatf("v%0d wr_count", i), wr_count, 32'(vecs[i].e_wc));
            tick();
        end

        // Reset mid-stream with two CPU reads in flight.
        drive(0, 0, 0, 0, 0, 1, 8'h20);
        @(negedge CLK);
        check("mid gnt0", cpu_gnt, 1);
        tick();
        @(negedge CLK);
        check("mid gnt1", cpu_gnt, 1);
        tick();
        check("mid csb before", sram_csb, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        check("mid csb async", sram_csb, 1);
        check("mid cpu_rvalid", cpu_rvalid, 0);
        check("mid wr_count", wr_count, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("post rst cpu_rvalid", cpu_rvalid, 0);
            check("post rst ld_rvalid", ld_rvalid, 0);
            tick();
        end
        check("post rst cpu_rdata", cpu_rdata, 0);

        // Mode switch while a CPU read is in flight.
        drive(0, 0, 0, 0, 0, 1, 8'h20);
        @(negedge CLK);
        check("sw cpu_gnt", cpu_gnt, 1);
        tick();
        drive(1, 1, 0, 8'h10, 0, 1, 8'h20);
        @(negedge CLK);
        check("sw ld_gnt", ld_gnt, 1);
        check("sw cpu_gnt off", cpu_gnt, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        check("sw cpu_rvalid", cpu_rvalid, 1);
        check("sw cpu_rdata", cpu_rdata, 32'h22220020);
        check("sw ld_rvalid early", ld_rvalid, 0);
        tick();
        @(negedge CLK);
        check("sw ld_rvalid", ld_rvalid, 1);
        check("sw ld_rdata", ld_rdata, 32'h11110010);
        tick();

        // Full load: 256 writes of address*3, then one more to show saturation.
        for (int a = 0; a < 256; a++) begin
            drive(1, 1, 1, 8'(a), 32'(a * 3), 0, 0);
            @(negedge CLK);
            check("load gnt", ld_gnt, 1);
            tick();
        end
        drive(1, 1, 1, 8'h00, 32'h0, 0, 0);
        @(negedge CLK);
        check("load wr_count 256", wr_count, 256);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        check("load wr_count sat", wr_count, 256);
        tick();

        // Streaming CPU fetches of every word; one result per cycle.
        rv_cnt = 0;
        for (int a = 0; a < 258; a++) begin
            if (a < 256) drive(0, 0, 0, 0, 0, 1, 8'(a));
            else         drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge CLK);
            if (a < 256) begin
                check("fetch gnt", cpu_gnt, 1);
                exp_q.push_back(32'(a * 3));
            end
            if (a >= 2) check("fetch rvalid", cpu_rvalid, 1);
            if (cpu_rvalid) begin
                rv_cnt++;
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("fetch data", cpu_rdata, want);
                end else begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL fetch extra: got rvalid with %h, expected none", cpu_rdata);
                end
            end
            tick();
        end
        check("fetch count", rv_cnt, 256);
        check("fetch queue empty", exp_q.size(), 0);

        // Mode lock for 10 cycles, then release.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 0, 1, 8'h00);
            @(negedge CLK);
            check("lock cpu_gnt", cpu_gnt, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 8'h00);
        @(negedge CLK);
        check("unlock cpu_gnt", cpu_gnt, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
